// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array output collector.
package sa_pkg;

    localparam int SA_HEIGHT     = 8;
    localparam int SA_WIDTH      = 8;
    localparam int SA_DATA_WIDTH = 8;
    localparam int SA_ACC_WIDTH  = 20;
    localparam int SA_SHIFT      = 4;

    typedef logic signed [SA_ACC_WIDTH-1:0]  acc_t;
    typedef logic signed [SA_DATA_WIDTH-1:0] elem_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Bit positions inside op_i = {reLU_sel, op_sel, flatten}
    localparam int OP_RELU = 2;
    localparam int OP_SEL  = 1;
    localparam int OP_FLAT = 0;

    localparam logic OPSEL_CONV = 1'b0;
    localparam logic OPSEL_MUL  = 1'b1;

endpackage

// File: rtl/sa_requant.sv
// One output element: acc + bias, arithmetic shift (floor), optional ReLU, 8-bit saturation.
module sa_requant
    import sa_pkg::*;
(
    input  acc_t  acc_i,
    input  elem_t bias_i,
    input  logic  relu_i,
    output elem_t elem_o
);

    localparam int SW = SA_ACC_WIDTH + 1;
    localparam logic signed [SW-1:0] MAX_V = SW'((2 ** (SA_DATA_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] MIN_V = SW'(-(2 ** (SA_DATA_WIDTH - 1)));

    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] shifted;
    logic signed [SW-1:0] rectified;

    always_comb begin
        sum       = {acc_i[SA_ACC_WIDTH-1], acc_i}
                  + {{(SW - SA_DATA_WIDTH){bias_i[SA_DATA_WIDTH-1]}}, bias_i};
        shifted   = sum >>> SA_SHIFT;
        rectified = (relu_i && shifted[SW-1]) ? '0 : shifted;
        if (rectified > MAX_V) begin
            elem_o = MAX_V[SA_DATA_WIDTH-1:0];
        end else if (rectified < MIN_V) begin
            elem_o = MIN_V[SA_DATA_WIDTH-1:0];
        end else begin
            elem_o = rectified[SA_DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/sa_output_collector.sv
// Collects SA output rows into an ofmap tile, requantises each element and
// signals completion back to the register file (and the DNN result on the last layer).
module sa_output_collector
    import sa_pkg::*;
#(
    parameter int HEIGHT     = SA_HEIGHT,
    parameter int WIDTH      = SA_WIDTH,
    parameter int DATA_WIDTH = SA_DATA_WIDTH,
    parameter int ACC_WIDTH  = SA_ACC_WIDTH
) (
    input  logic                               clk,
    input  logic                               nrst,
    input  logic                               start_i,
    input  logic [3:0]                         out_height_i,
    input  logic [3:0]                         out_width_i,
    input  logic [2:0]                         op_i,
    input  logic                               is_final_layer_i,
    input  logic [HEIGHT*WIDTH*DATA_WIDTH-1:0] bias_i,
    input  logic                               sa_row_iv,
    input  logic [WIDTH*ACC_WIDTH-1:0]         sa_row_id,
    output logic                               ofmap_ov,
    output logic [HEIGHT*WIDTH*DATA_WIDTH-1:0] ofmap_od,
    output logic                               received_SA_od,
    output logic                               dnn_iv,
    output logic [DATA_WIDTH-1:0]              dnn_id,
    output logic                               busy_o
);

    localparam int RW = $clog2(HEIGHT);

    state_t                             state_q;
    logic [RW-1:0]                      row_cnt_q;
    logic [3:0]                         out_h_q, out_w_q;
    logic [3:0]                         out_h_d, out_w_d;
    logic [2:0]                         op_q;
    logic                               final_q;
    logic [HEIGHT*WIDTH*DATA_WIDTH-1:0] bias_q;
    elem_t                              ofmap_q [HEIGHT][WIDTH];
    elem_t                              row_elem [WIDTH];
    logic                               ofmap_ov_q, received_q, dnn_iv_q;
    elem_t                              dnn_id_q;
    logic                               unused_flat;

    // flatten only matters further downstream
    assign unused_flat = op_i[OP_FLAT];

    assign out_h_d = (out_height_i > 4'(HEIGHT)) ? 4'(HEIGHT) : out_height_i;
    assign out_w_d = (out_width_i  > 4'(WIDTH))  ? 4'(WIDTH)  : out_width_i;

    for (genvar c = 0; c < WIDTH; c++) begin : g_col
        acc_t  acc;
        elem_t bias_sel;
        elem_t req;

        assign acc      = sa_row_id[c*ACC_WIDTH +: ACC_WIDTH];
        // MUL carries a per-element bias; CONV broadcasts the single bias at [0][0]
        assign bias_sel = (op_q[OP_SEL] == OPSEL_MUL)
                        ? bias_q[(int'(row_cnt_q)*WIDTH + c)*DATA_WIDTH +: DATA_WIDTH]
                        : bias_q[DATA_WIDTH-1:0];

        sa_requant u_requant (
            .acc_i  (acc),
            .bias_i (bias_sel),
            .relu_i (op_q[OP_RELU]),
            .elem_o (req)
        );

        assign row_elem[c] = (4'(c) < out_w_q) ? req : '0;
    end

    for (genvar r = 0; r < HEIGHT; r++) begin : g_out_r
        for (genvar c = 0; c < WIDTH; c++) begin : g_out_c
            assign ofmap_od[(r*WIDTH + c)*DATA_WIDTH +: DATA_WIDTH] = ofmap_q[r][c];
        end
    end

    // sa_row_iv is a pure qualifier with no back-pressure: every cycle it is high
    // during COLLECT one row is taken; it is ignored in any other state.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            row_cnt_q  <= '0;
            out_h_q    <= '0;
            out_w_q    <= '0;
            op_q       <= '0;
            final_q    <= 1'b0;
            bias_q     <= '0;
            ofmap_ov_q <= 1'b0;
            received_q <= 1'b0;
            dnn_iv_q   <= 1'b0;
            dnn_id_q   <= '0;
            for (int r = 0; r < HEIGHT; r++) begin
                for (int c = 0; c < WIDTH; c++) begin
                    ofmap_q[r][c] <= '0;
                end
            end
        end else begin
            ofmap_ov_q <= 1'b0;
            received_q <= 1'b0;
            dnn_iv_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        out_h_q   <= out_h_d;
                        out_w_q   <= out_w_d;
                        op_q      <= op_i;
                        final_q   <= is_final_layer_i;
                        bias_q    <= bias_i;
                        row_cnt_q <= '0;
                        for (int r = 0; r < HEIGHT; r++) begin
                            for (int c = 0; c < WIDTH; c++) begin
                                ofmap_q[r][c] <= '0;
                            end
                        end
                        state_q <= (out_h_d == 4'd0) ? ST_DONE : ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (sa_row_iv) begin
                        for (int c = 0; c < WIDTH; c++) begin
                            ofmap_q[row_cnt_q][c] <= row_elem[c];
                        end
                        row_cnt_q <= row_cnt_q + 1'b1;
                        if (4'(row_cnt_q) == out_h_q - 4'd1) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    ofmap_ov_q <= 1'b1;
                    received_q <= 1'b1;
                    if (final_q) begin
                        dnn_iv_q <= 1'b1;
                        dnn_id_q <= ofmap_q[0][0];
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ofmap_ov       = ofmap_ov_q;
    assign received_SA_od = received_q;
    assign dnn_iv         = dnn_iv_q;
    assign dnn_id         = dnn_id_q;
    assign busy_o         = (state_q == ST_COLLECT);

endmodule

// File: tb/tb_sa_output_collector.sv
// Self-checking bench for sa_output_collector: vector table plus scoreboard of expected tiles.
module tb_sa_output_collector;

    localparam int H  = 8;
    localparam int W  = 8;
    localparam int DW = 8;
    localparam int AW = 20;
    localparam int TW = H*W*DW;

    logic            clk;
    logic            nrst;
    logic            start_i;
    logic [3:0]      out_height_i;
    logic [3:0]      out_width_i;
    logic [2:0]      op_i;
    logic            is_final_layer_i;
    logic [TW-1:0]   bias_i;
    logic            sa_row_iv;
    logic [W*AW-1:0] sa_row_id;
    logic            ofmap_ov;
    logic [TW-1:0]   ofmap_od;
    logic            received_SA_od;
    logic            dnn_iv;
    logic [DW-1:0]   dnn_id;
    logic            busy_o;

    sa_output_collector dut (
        .clk              (clk),
        .nrst             (nrst),
        .start_i          (start_i),
        .out_height_i     (out_height_i),
        .out_width_i      (out_width_i),
        .op_i             (op_i),
        .is_final_layer_i (is_final_layer_i),
        .bias_i           (bias_i),
        .sa_row_iv        (sa_row_iv),
        .sa_row_id        (sa_row_id),
        .ofmap_ov         (ofmap_ov),
        .ofmap_od         (ofmap_od),
        .received_SA_od   (received_SA_od),
        .dnn_iv           (dnn_iv),
        .dnn_id           (dnn_id),
        .busy_o           (busy_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [TW+DW:0] exp_q [$];
    logic [TW-1:0]  prev_tile;
    logic           prev_ov;
    int             bias_a [H][W];
    int             sa_a   [H][W];

    typedef struct {
        logic [2:0] op;
        int h; int w; int fin;
        int b0; int b1; int s0; int s1;
        int e0; int e1;
    } vec_t;
    vec_t vecs [11];

    task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model(input int acc, input int b, input bit relu);
        int v;
        int q;
        v = acc + b;
        if (v >= 0) q = v / 16;
        else        q = -((-v + 15) / 16);
        if (relu && q < 0) q = 0;
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return q[7:0];
    endfunction

    initial prev_ov = 1'b0;
    always @(negedge clk) begin
        logic [TW+DW:0] pkt;
        if (prev_ov) check("pulse_width", {511'b0, ofmap_ov}, '0);
        if (ofmap_ov) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse actual=1 expected=0");
            end else begin
                pkt = exp_q.pop_front();
                check("sb_ofmap", ofmap_od, pkt[TW-1:0]);
                check("sb_received", {511'b0, received_SA_od}, 1);
                check("sb_dnn_iv", {511'b0, dnn_iv}, {511'b0, pkt[TW+DW]});
                if (pkt[TW+DW]) check("sb_dnn_id", {504'b0, dnn_id}, {504'b0, pkt[TW+DW-1:TW]});
            end
        end else if (received_SA_od || dnn_iv) begin
            checks++;
            failures++;
            $display("FAIL stray_pulse received=%0b dnn_iv=%0b expected=0", received_SA_od, dnn_iv);
        end
        prev_ov <= ofmap_ov;
    end

    // ---------------- driver ----------------
    task automatic load_row(input int r);
        for (int c = 0; c < W; c++) sa_row_id[c*AW +: AW] = AW'(sa_a[r][c]);
    endtask

    task automatic run_vec(input vec_t v);
        int he, we, g, b;
        logic [TW-1:0] tile;
        logic [7:0] e0b, e1b;
        he = (v.h > H) ? H : v.h;
        we = (v.w > W) ? W : v.w;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                bias_a[r][c] = int'($urandom_range(255)) - 128;
                sa_a[r][c]   = int'($urandom_range(8000)) - 4000;
            end
        end
        bias_a[0][0] = v.b0; bias_a[0][1] = v.b1;
        sa_a[0][0]   = v.s0; sa_a[0][1]   = v.s1;
        tile = '0;
        for (int r = 0; r < he; r++) begin
            for (int c = 0; c < we; c++) begin
                b = v.op[1] ? bias_a[r][c] : bias_a[0][0];
                tile[(r*W + c)*DW +: DW] = model(sa_a[r][c], b, v.op[2]);
            end
        end

        // stray row while idle must not touch the stored tile
        sa_row_iv = 1'b1;
        load_row(H - 1);
        @(posedge clk); #1;
        sa_row_iv = 1'b0;
        @(negedge clk);
        check("idle_stable", ofmap_od, prev_tile);

        op_i             = v.op;
        out_height_i     = 4'(v.h);
        out_width_i      = 4'(v.w);
        is_final_layer_i = (v.fin != 0);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) bias_i[(r*W + c)*DW +: DW] = 8'(bias_a[r][c]);
        start_i = 1'b1;
        exp_q.push_back({(v.fin != 0), (v.fin != 0) ? tile[DW-1:0] : 8'h00, tile});
        @(posedge clk); #1;
        start_i          = 1'b0;
        op_i             = ~v.op;
        out_height_i     = 4'd5;
        out_width_i      = 4'd1;
        is_final_layer_i = (v.fin == 0);
        bias_i           = {16{$urandom()}};

        if (he > 0) begin
            @(negedge clk);
            check("busy_collect", {511'b0, busy_o}, 1);
            for (int r = 0; r < he; r++) begin
                g = $urandom_range(2);
                repeat (g) begin
                    start_i = 1'b1;
                    @(posedge clk); #1;
                    start_i = 1'b0;
                end
                sa_row_iv = 1'b1;
                load_row(r);
                @(posedge clk); #1;
                sa_row_iv = 1'b0;
                sa_row_id = {5{$urandom()}};
            end
        end
        @(negedge clk);
        check("latency_early", {511'b0, ofmap_ov}, 0);
        @(negedge clk);
        check("latency_pulse", {511'b0, ofmap_ov}, 1);
        e0b = 8'(v.e0);
        e1b = 8'(v.e1);
        check("hand_e00", {504'b0, ofmap_od[7:0]}, {504'b0, e0b});
        check("hand_e01", {504'b0, ofmap_od[15:8]}, {504'b0, e1b});
        check("busy_after", {511'b0, busy_o}, 0);
        prev_tile = tile;
        @(posedge clk); #1;
    endtask

    // ---------------- test ----------------
    initial begin
        //            op      h   w  fin  b0   b1   s0     s1    e0    e1
        vecs[0]  = '{3'b010,  2,  2, 0,   12,  0,   100,   -65,  7,    -5};
        vecs[1]  = '{3'b010,  1,  2, 0,   0,   0,   5000,  -5000, 127, -128};
        vecs[2]  = '{3'b110,  1,  2, 0,   0,   0,   -64,   -64,  0,    0};
        vecs[3]  = '{3'b010,  1,  2, 0,   0,   0,   -64,   -64,  -4,   -4};
        vecs[4]  = '{3'b000,  1,  3, 0,   16,  99,  0,     16,   1,    2};
        vecs[5]  = '{3'b100, 12, 12, 0,   -40, 5,   -100,  600,  0,    35};
        vecs[6]  = '{3'b001,  1,  1, 1,   0,   0,   160,   50,   10,   0};
        vecs[7]  = '{3'b110,  8,  8, 1,   -20, 7,   500,   -30,  30,   0};
        vecs[8]  = '{3'b010,  3,  0, 0,   5,   5,   300,   300,  0,    0};
        vecs[9]  = '{3'b010,  0,  4, 0,   5,   5,   300,   300,  0,    0};
        vecs[10] = '{3'b011,  5,  6, 0,   1,   -1,  -1,    17,   0,    1};

        nrst = 1'b0; start_i = 1'b0; out_height_i = '0; out_width_i = '0;
        op_i = '0; is_final_layer_i = 1'b0; bias_i = '0; sa_row_iv = 1'b0; sa_row_id = '0;
        prev_tile = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ofmap", ofmap_od, '0);
        check("rst_ov", {511'b0, ofmap_ov}, 0);
        check("rst_received", {511'b0, received_SA_od}, 0);
        check("rst_dnn_iv", {511'b0, dnn_iv}, 0);
        check("rst_dnn_id", {504'b0, dnn_id}, 0);
        check("rst_busy", {511'b0, busy_o}, 0);
        nrst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // reset in the middle of a collection: everything clears, no pulse follows
        op_i = 3'b010; out_height_i = 4'd4; out_width_i = 4'd4; is_final_layer_i = 1'b1;
        bias_i = {16{$urandom()}};
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int r = 0; r < 2; r++) begin
            sa_row_iv = 1'b1;
            sa_row_id = {5{$urandom()}};
            @(posedge clk); #1;
        end
        sa_row_iv = 1'b0;
        #2 nrst = 1'b0;
        #1;
        check("midrst_ofmap", ofmap_od, '0);
        check("midrst_busy", {511'b0, busy_o}, 0);
        check("midrst_dnn_id", {504'b0, dnn_id}, 0);
        @(posedge clk); #1;
        nrst = 1'b1;
        sa_row_iv = 1'b1;
        repeat (6) @(negedge clk);
        sa_row_iv = 1'b0;
        check("midrst_ofmap_after", ofmap_od, '0);
        check("sb_drained", TW'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
